// File: rtl/pipe_stage_skid_reg.sv
// Inter-stage pipeline register with a two-entry skid buffer.
// in_ready comes from a flop, so a downstream stall never reaches the
// upstream stage combinationally. Flush inserts a bubble, and control bits
// are forced to zero in any empty slot. A saturating counter records
// bubble cycles for CPI profiling.
module pipe_stage_skid_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 111,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  bubble_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0] main_data_q, skid_data_q;
  logic              in_ready_q;
  logic [CNT_W-1:0]  bubble_q;

  logic accept;
  logic drain;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid_in;

  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid && in_ready_q;
  assign drain     = out_valid && out_ready;

  // Next-state and entry-load decisions; flush overrides every transition.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    if (flush_in) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            load_main_in = 1'b1;
            state_d      = ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            load_skid_in = 1'b1;
            state_d      = FULL;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            load_main_skid = 1'b1;
            state_d        = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State register; in_ready is registered from the next state.
  always_ff @(posedge clk) begin
    if (reset_in) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  // MAIN and SKID entries; flush and reset wipe both so nothing stale survives.
  always_ff @(posedge clk) begin
    if (reset_in || flush_in) begin
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      if (load_main_in) begin
        main_ctrl_q <= in_ctrl;
        main_data_q <= in_data;
      end else if (load_main_skid) begin
        main_ctrl_q <= skid_ctrl_q;
        main_data_q <= skid_data_q;
      end
      if (load_skid_in) begin
        skid_ctrl_q <= in_ctrl;
        skid_data_q <= in_data;
      end
    end
  end

  // Saturating count of cycles where downstream was ready but we had nothing.
  always_ff @(posedge clk) begin
    if (reset_in) begin
      bubble_q <= '0;
    end else if (!out_valid && out_ready && (bubble_q != {CNT_W{1'b1}})) begin
      bubble_q <= bubble_q + CNT_W'(1);
    end
  end

  assign in_ready     = in_ready_q;
  assign out_ctrl     = out_valid ? main_ctrl_q : '0;
  assign out_data     = main_data_q;
  assign bubble_count = bubble_q;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Self-checking bench for pipe_stage_skid_reg. Directed phases drive the
// stage. A negedge monitor keeps a FIFO scoreboard of accepted entries and
// checks order, occupancy, in_ready and the bubble counter every cycle.
module tb_pipe_stage_skid_reg;

  localparam int CTRL_W = 8;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset_in = 1'b1;
  logic              in_valid = 1'b1;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              flush_in = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  bubble_count;

  typedef struct packed {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } item_t;

  item_t sb[$];
  int    errors = 0;
  int    checks = 0;
  int    exp_bubble = 0;

  pipe_stage_skid_reg #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .reset_in    (reset_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_ctrl     (in_ctrl),
    .in_data     (in_data),
    .flush_in    (flush_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ctrl    (out_ctrl),
    .out_data    (out_data),
    .bubble_count(bubble_count)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [CTRL_W-1:0] c,
                               input logic [DATA_W-1:0] d, input logic r, input logic f);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = r;
    flush_in  = f;
  endtask

  task automatic doReset(input int n);
    @(posedge clk);
    #1;
    reset_in  = 1'b1;
    in_valid  = 1'b1;
    in_ctrl   = '1;
    in_data   = '1;
    out_ready = 1'b0;
    flush_in  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset_in = 1'b0;
    in_valid = 1'b0;
    in_ctrl  = '0;
    in_data  = '0;
  endtask

  // Scoreboard monitor: checks the visible slot, then advances the model.
  always @(negedge clk) begin
    logic  exp_valid;
    logic  exp_ready;
    item_t head;
    item_t incoming;
    if (reset_in) begin
      sb.delete();
      exp_bubble = 0;
    end else begin
      exp_valid = (sb.size() != 0);
      exp_ready = (sb.size() < 2);
      checkOutput("out_valid", 64'(out_valid), 64'(exp_valid));
      checkOutput("in_ready", 64'(in_ready), 64'(exp_ready));
      checkOutput("bubble_count", 64'(bubble_count), 64'(exp_bubble));
      if (!exp_valid) checkOutput("bubble_ctrl_zero", 64'(out_ctrl), 64'd0);
      if (!exp_valid && out_ready && exp_bubble < 15) exp_bubble++;
      if (exp_valid && out_ready) begin
        head = sb.pop_front();
        checkOutput("sb_ctrl", 64'(out_ctrl), 64'(head.c));
        checkOutput("sb_data", 64'(out_data), 64'(head.d));
      end
      if (flush_in) begin
        sb.delete();
      end else if (in_valid && exp_ready) begin
        incoming.c = in_ctrl;
        incoming.d = in_data;
        sb.push_back(incoming);
      end
    end
  end

  // Directed phases followed by a random valid/ready/flush run.
  initial begin
    // Reset with in_valid held high.
    doReset(2);
    @(negedge clk);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    checkOutput("rst_out_data", 64'(out_data), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_bubble", 64'(bubble_count), 64'd0);

    // Back-to-back streaming 0x01..0x10.
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, CTRL_W'(i) ^ 8'hA5, DATA_W'(i), 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("stream_in_ready", 64'(in_ready), 64'd1);
      if (i > 1) checkOutput("stream_data", 64'(out_data), 64'(i - 1));
    end
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("stream_last", 64'(out_data), 64'h10);

    // Stall with skid: A then B, downstream blocked.
    applyStimulus(1'b1, 8'h3C, 16'hAAAA, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'hC3, 16'hBBBB, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("stall_a_out", 64'(out_data), 64'hAAAA);
    checkOutput("stall_one_ready", 64'(in_ready), 64'd1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("stall_full_ready", 64'(in_ready), 64'd0);
    checkOutput("stall_a_held", 64'(out_data), 64'hAAAA);
    checkOutput("stall_a_ctrl", 64'(out_ctrl), 64'h3C);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("stall_a_held2", 64'(out_data), 64'hAAAA);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("drain_a", 64'(out_data), 64'hAAAA);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("drain_b", 64'(out_data), 64'hBBBB);
    checkOutput("drain_b_ready", 64'(in_ready), 64'd1);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);

    // Flush while FULL with a same-cycle input C.
    applyStimulus(1'b1, 8'h11, 16'h1111, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h22, 16'h2222, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h33, 16'h3333, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("pre_flush_full", 64'(in_ready), 64'd0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("flush_valid", 64'(out_valid), 64'd0);
    checkOutput("flush_ctrl", 64'(out_ctrl), 64'd0);
    checkOutput("flush_data", 64'(out_data), 64'd0);
    checkOutput("flush_ready", 64'(in_ready), 64'd1);
    repeat (3) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);

    // Bubble counter saturation with CNT_W=4.
    doReset(1);
    out_ready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
      if (i == 7) begin
        @(negedge clk);
        checkOutput("bubble_7", 64'(bubble_count), 64'd7);
      end
    end
    @(negedge clk);
    checkOutput("bubble_sat", 64'(bubble_count), 64'd15);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("bubble_hold", 64'(bubble_count), 64'd15);

    // Reset in the middle of a full stage.
    applyStimulus(1'b1, 8'h44, 16'h4444, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h55, 16'h5555, 1'b0, 1'b0);
    doReset(1);
    @(negedge clk);
    checkOutput("midrst_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_ready", 64'(in_ready), 64'd1);
    checkOutput("midrst_bubble", 64'(bubble_count), 64'd0);
    checkOutput("midrst_data", 64'(out_data), 64'd0);

    // Random traffic; ctrl is forced nonzero so bubble zeroing is visible.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), CTRL_W'($urandom) | 8'h01,
                    DATA_W'($urandom), 1'($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 15) == 0));
    end

    // Drain whatever is left, bounded.
    for (int i = 0; i < 10 && sb.size() != 0; i++) begin
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
      @(negedge clk);
    end
    checkOutput("drain_timeout", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
